// File: rtl/guess_seq_engine_pkg.sv
// Shared types and width helpers for the key-sequence guessing engine.
package guess_pkg;

    typedef enum logic [2:0] {
        SET   = 3'd0,
        GUESS = 3'd1,
        CHECK = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } phase_e;

    function automatic int key_w(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int turn_w(input int max_turns);
        return $clog2(max_turns + 1);
    endfunction

    localparam int DEF_NUM_KEYS = 4;

    typedef logic [key_w(DEF_NUM_KEYS)-1:0] key_idx_t;

endpackage

// File: rtl/guess_seq_engine_key_event.sv
// Registers key/enter levels and turns them into single-key and enter rising-edge events.
module key_event
    import guess_pkg::*;
#(
    parameter  int NUM_KEYS = 4,
    localparam int KEY_W    = key_w(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                enter,
    output logic                key_vld,
    output logic [KEY_W-1:0]    key_idx,
    output logic [NUM_KEYS-1:0] key_onehot,
    output logic                enter_vld
);

    logic [NUM_KEYS-1:0] keys_r;
    logic [NUM_KEYS-1:0] keys_d_r;
    logic                enter_r;
    logic                enter_d_r;
    logic [NUM_KEYS-1:0] rise_s;
    logic [KEY_W-1:0]    key_idx_s;

    // Input sampling register plus one-cycle history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_r    <= {NUM_KEYS{1'b0}};
            keys_d_r  <= {NUM_KEYS{1'b0}};
            enter_r   <= 1'b0;
            enter_d_r <= 1'b0;
        end else begin
            keys_r    <= keys;
            keys_d_r  <= keys_r;
            enter_r   <= enter;
            enter_d_r <= enter_r;
        end
    end

    // Binary index of the rising key; only meaningful when exactly one key rose.
    always_comb begin
        rise_s    = keys_r & ~keys_d_r;
        key_idx_s = {KEY_W{1'b0}};
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_idx_s = rise_s[i] ? KEY_W'(i) : key_idx_s;
        end
    end

    // Enter has priority: a key rising together with enter is dropped.
    assign enter_vld  = enter_r & ~enter_d_r;
    assign key_vld    = $onehot(rise_s) & ~enter_vld;
    assign key_idx    = key_idx_s;
    assign key_onehot = rise_s;

endmodule

// File: rtl/guess_seq_engine.sv
// Guessing-game engine: secret/guess entry, serial one-position-per-clock scoring, turn tracking.
module guess_seq_engine
    import guess_pkg::*;
#(
    parameter  int NUM_KEYS  = 4,
    parameter  int MAX_LEN   = 7,
    parameter  int MIN_LEN   = 4,
    parameter  int MAX_TURNS = 3,
    localparam int KEY_W     = key_w(NUM_KEYS),
    localparam int LEN_W     = len_w(MAX_LEN),
    localparam int TURN_W    = turn_w(MAX_TURNS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                enter,
    output logic                win,
    output logic                lose,
    output logic                equal,
    output logic                bigger,
    output logic                smaller,
    output logic [NUM_KEYS-1:0] nums,
    output logic [TURN_W-1:0]   turn,
    output logic [LEN_W-1:0]    match_cnt,
    output logic [2:0]          phase
);

    // Buffers are sized to the full index range so len/idx index them directly.
    localparam int DEPTH = 1 << LEN_W;

    logic                key_vld;
    logic [KEY_W-1:0]    key_idx;
    logic [NUM_KEYS-1:0] key_onehot;
    logic                enter_vld;

    phase_e              phase_r, phase_n;
    logic [KEY_W-1:0]    secret_r [DEPTH];
    logic [KEY_W-1:0]    secret_n [DEPTH];
    logic [KEY_W-1:0]    guess_r  [DEPTH];
    logic [KEY_W-1:0]    guess_n  [DEPTH];
    logic [LEN_W-1:0]    len_a_r, len_a_n, len_b_r, len_b_n;
    logic [LEN_W-1:0]    idx_r, idx_n, acc_r, acc_n;
    logic [LEN_W-1:0]    match_cnt_r, match_cnt_n;
    logic [TURN_W-1:0]   turn_r, turn_n;
    logic [NUM_KEYS-1:0] nums_r, nums_n;
    logic                win_r, win_n, lose_r, lose_n;
    logic                equal_r, equal_n, bigger_r, bigger_n, smaller_r, smaller_n;

    logic [LEN_W-1:0]    min_len_s;
    logic                pos_match_s;
    logic [LEN_W-1:0]    match_total_s;
    logic [TURN_W-1:0]   turn_inc_s;

    key_event #(.NUM_KEYS(NUM_KEYS)) u_key_event (
        .clk        (clk),
        .reset      (reset),
        .keys       (keys),
        .enter      (enter),
        .key_vld    (key_vld),
        .key_idx    (key_idx),
        .key_onehot (key_onehot),
        .enter_vld  (enter_vld)
    );

    assign min_len_s     = (len_a_r < len_b_r) ? len_a_r : len_b_r;
    assign pos_match_s   = (idx_r < min_len_s) && (secret_r[idx_r] == guess_r[idx_r]);
    assign match_total_s = acc_r + LEN_W'(pos_match_s);
    assign turn_inc_s    = turn_r + TURN_W'(1'b1);

    // Next-state and next-register logic for the whole game.
    always_comb begin
        phase_n     = phase_r;
        secret_n    = secret_r;
        guess_n     = guess_r;
        len_a_n     = len_a_r;
        len_b_n     = len_b_r;
        idx_n       = idx_r;
        acc_n       = acc_r;
        match_cnt_n = match_cnt_r;
        turn_n      = turn_r;
        nums_n      = nums_r;
        win_n       = win_r;
        lose_n      = lose_r;
        equal_n     = equal_r;
        bigger_n    = bigger_r;
        smaller_n   = smaller_r;
        case (phase_r)
            SET: begin
                if (enter_vld) begin
                    if (len_a_r >= LEN_W'(MIN_LEN)) begin
                        phase_n = GUESS;
                    end else begin
                        len_a_n = {LEN_W{1'b0}};
                        for (int i = 0; i < DEPTH; i++) secret_n[i] = {KEY_W{1'b0}};
                    end
                end else if (key_vld) begin
                    nums_n = key_onehot;
                    if (len_a_r < LEN_W'(MAX_LEN)) begin
                        secret_n[len_a_r] = key_idx;
                        len_a_n           = len_a_r + LEN_W'(1'b1);
                    end else begin
                        len_a_n = len_a_r;
                    end
                end else begin
                    nums_n = nums_r;
                end
            end
            GUESS: begin
                if (enter_vld) begin
                    if (len_b_r < LEN_W'(MIN_LEN)) begin
                        len_b_n = {LEN_W{1'b0}};
                        for (int i = 0; i < DEPTH; i++) guess_n[i] = {KEY_W{1'b0}};
                    end else begin
                        phase_n = CHECK;
                        idx_n   = {LEN_W{1'b0}};
                        acc_n   = {LEN_W{1'b0}};
                    end
                end else if (key_vld) begin
                    nums_n = key_onehot;
                    if (len_b_r < LEN_W'(MAX_LEN)) begin
                        guess_n[len_b_r] = key_idx;
                        len_b_n          = len_b_r + LEN_W'(1'b1);
                    end else begin
                        len_b_n = len_b_r;
                    end
                end else begin
                    nums_n = nums_r;
                end
            end
            CHECK: begin
                if (idx_r == LEN_W'(MAX_LEN - 1)) begin
                    idx_n       = {LEN_W{1'b0}};
                    acc_n       = {LEN_W{1'b0}};
                    match_cnt_n = match_total_s;
                    equal_n     = (len_b_r == len_a_r);
                    bigger_n    = (len_b_r < len_a_r);
                    smaller_n   = (len_b_r > len_a_r);
                    if ((len_a_r == len_b_r) && (match_total_s == len_a_r)) begin
                        win_n   = 1'b1;
                        phase_n = WIN;
                    end else begin
                        turn_n = turn_inc_s;
                        if (turn_inc_s == TURN_W'(MAX_TURNS)) begin
                            lose_n  = 1'b1;
                            phase_n = LOSE;
                        end else begin
                            phase_n = GUESS;
                            len_b_n = {LEN_W{1'b0}};
                            for (int i = 0; i < DEPTH; i++) guess_n[i] = {KEY_W{1'b0}};
                        end
                    end
                end else begin
                    idx_n = idx_r + LEN_W'(1'b1);
                    acc_n = match_total_s;
                end
            end
            WIN, LOSE: begin
                // A new round is indistinguishable from a fresh reset.
                if (enter_vld) begin
                    phase_n     = SET;
                    len_a_n     = {LEN_W{1'b0}};
                    len_b_n     = {LEN_W{1'b0}};
                    idx_n       = {LEN_W{1'b0}};
                    acc_n       = {LEN_W{1'b0}};
                    match_cnt_n = {LEN_W{1'b0}};
                    turn_n      = {TURN_W{1'b0}};
                    nums_n      = {NUM_KEYS{1'b0}};
                    win_n       = 1'b0;
                    lose_n      = 1'b0;
                    equal_n     = 1'b0;
                    bigger_n    = 1'b0;
                    smaller_n   = 1'b0;
                    for (int i = 0; i < DEPTH; i++) begin
                        secret_n[i] = {KEY_W{1'b0}};
                        guess_n[i]  = {KEY_W{1'b0}};
                    end
                end else begin
                    phase_n = phase_r;
                end
            end
            default: begin
                phase_n = SET;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r     <= SET;
            len_a_r     <= {LEN_W{1'b0}};
            len_b_r     <= {LEN_W{1'b0}};
            idx_r       <= {LEN_W{1'b0}};
            acc_r       <= {LEN_W{1'b0}};
            match_cnt_r <= {LEN_W{1'b0}};
            turn_r      <= {TURN_W{1'b0}};
            nums_r      <= {NUM_KEYS{1'b0}};
            win_r       <= 1'b0;
            lose_r      <= 1'b0;
            equal_r     <= 1'b0;
            bigger_r    <= 1'b0;
            smaller_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                secret_r[i] <= {KEY_W{1'b0}};
                guess_r[i]  <= {KEY_W{1'b0}};
            end
        end else begin
            phase_r     <= phase_n;
            len_a_r     <= len_a_n;
            len_b_r     <= len_b_n;
            idx_r       <= idx_n;
            acc_r       <= acc_n;
            match_cnt_r <= match_cnt_n;
            turn_r      <= turn_n;
            nums_r      <= nums_n;
            win_r       <= win_n;
            lose_r      <= lose_n;
            equal_r     <= equal_n;
            bigger_r    <= bigger_n;
            smaller_r   <= smaller_n;
            for (int i = 0; i < DEPTH; i++) begin
                secret_r[i] <= secret_n[i];
                guess_r[i]  <= guess_n[i];
            end
        end
    end

    assign win       = win_r;
    assign lose      = lose_r;
    assign equal     = equal_r;
    assign bigger    = bigger_r;
    assign smaller   = smaller_r;
    assign nums      = nums_r;
    assign turn      = turn_r;
    assign match_cnt = match_cnt_r;
    assign phase     = phase_r;

endmodule

// File: doc/guess_seq_engine.md
Name: guess_seq_engine

Overview:
Clocked, parametrised successor to the key-sequence guessing game. Player A enters a secret key sequence; player B gets MAX_TURNS guesses. Each guess is scored serially, one position per clock, for length relation and number of positional matches. The block sits between the debounced front-panel keys and the LED/score display logic.

Parameters:
NUM_KEYS, 4, number of input keys (>=2)
MAX_LEN, 7, maximum stored sequence length (>=1)
MIN_LEN, 4, minimum length accepted on enter (1..MAX_LEN)
MAX_TURNS, 3, failed guesses allowed before lose (>=1)

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-high reset
keys  in  NUM_KEYS  debounced, clk-synchronous key levels
enter  in  1  debounced, clk-synchronous enter level
win  out  1  guess fully matched the secret
lose  out  1  MAX_TURNS failed guesses used
equal  out  1  last scored guess length == secret length
bigger  out  1  last scored guess shorter than secret
smaller  out  1  last scored guess longer than secret
nums  out  NUM_KEYS  one-hot echo of the last valid key press
turn  out  TURN_W  failed-guess count
match_cnt  out  LEN_W  matching positions in the last scored guess
phase  out  3  current phase_e state

Behaviour:
- Widths: KEY_W=clog2(NUM_KEYS); LEN_W=clog2(MAX_LEN+1); TURN_W=clog2(MAX_TURNS+1).
- Events: keys and enter are registered once. A key event is the rising edge of exactly one key. If two or more keys rise in the same cycle, the cycle is ignored. An enter event is the rising edge of enter. Enter wins over a simultaneous key event, and the key event is dropped.
- Reset: state SET. All outputs are 0. Secret and guess buffers and lengths are cleared, and turn=0.
- SET: on a key event, nums is set to that key's one-hot. The key index is appended to secret[len_a] if len_a<MAX_LEN. If the buffer is full, the key is not stored, but nums still updates.
- SET, on enter: if len_a>=MIN_LEN, go to GUESS. Otherwise clear the secret, set len_a=0, and stay in SET.
- GUESS: keys append to the guess buffer with the same rules as SET.
- GUESS, on enter: if len_b<MIN_LEN, clear the guess. No turn is consumed and no flag changes. Otherwise go to CHECK with idx=0 and the match accumulator at 0.
- CHECK: lasts exactly MAX_LEN cycles, with idx running 0..MAX_LEN-1. Position idx counts as a match iff idx<min(len_a,len_b) and secret[idx]==guess[idx]. Keys and enter are ignored during CHECK.
- CHECK exit, on the edge ending the last CHECK cycle:
  - match_cnt is updated. Exactly one of equal/bigger/smaller is set.
  - win=1 iff len_a==len_b and match_cnt==len_a; the next state is then WIN.
  - Otherwise turn+1 is applied. If the new turn==MAX_TURNS, lose=1 and the next state is LOSE. Otherwise clear the guess and return to GUESS.
- Latency: flags are visible MAX_LEN+1 clocks after the edge that first samples enter high.
- WIN and LOSE are terminal. Keys are ignored there. An enter event starts a new round: the state becomes equivalent to reset, with all buffers, flags, turn and nums cleared.
- Flags stay 0 until the first compare. Flags and match_cnt hold their values between compares.
- Reset asserted mid-CHECK or mid-entry aborts immediately to reset values. There is no partial commit.

Decomposition:
- Package guess_pkg holds:
  - phase_e enum: SET=0, GUESS=1, CHECK=2, WIN=3, LOSE=4.
  - Width helper functions for KEY_W, LEN_W and TURN_W.
  - key_idx_t typedef.
- Sub-module key_event (in guess_pkg widths) handles input registration, edge detection and the one-hot validity check. Its outputs are key_vld, key_idx, key_onehot and enter_vld.
- The top level holds the FSM, both buffers and the serial comparator.

Test Plan:
- Defaults: secret 1,2,3,4 and enter, then guess 1,2,3,4 and enter -> phase CHECK for 7 clocks. At clock 8: win=1, equal=1, match_cnt=4, turn=0, phase=WIN.
- Secret 1,2,3,4; guesses 4,3,2,1 three times -> turn steps 1, 2, 3. After the third guess, lose=1 and phase=LOSE. match_cnt=0 each time.
- Secret 1,2,3,4; guess 1,2,3,4,1 -> smaller=1, match_cnt=4, turn=1. Then guess 1,2,4 and enter -> guess cleared, turn stays 1, flags unchanged.
- Secret entry of 3 keys then enter -> stays in SET with len cleared. Then 8 key presses -> only 7 stored, and nums shows the 8th key.
- Keys 1 and 2 rising together, then key 3 rising together with enter -> nums unchanged and nothing stored. The enter is processed.
- Reset asserted in the 3rd CHECK cycle -> all outputs 0 and phase=SET at once. A following enter event in WIN restarts cleanly to SET.
